// File: rtl/mips_fetch_if.sv
// Fetch-stage bus: instruction RAM port, redirect request from execute, and fetch status.
// fsm_state is a debug view of the sequencer state: 0 = RUN, 1 = DELAY, 2 = HALTED.
interface mips_fetch_if;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] instr_readdata;
   logic [31:0] instr_address;
   logic [31:0] instr;
   logic [31:0] pc;
   logic [31:0] pc_plus8;
   logic        active;
   logic        fault;
   logic        ds_err;
   logic [1:0]  fsm_state;

   // Redirects are single-cycle requests with no ready: they are sampled only on an
   // unstalled rising edge in RUN, and dropped (flagged via ds_err) in DELAY.
   modport master (
      input  stall, redirect_valid, redirect_target, instr_readdata,
      output instr_address, instr, pc, pc_plus8, active, fault, ds_err, fsm_state
   );

   modport slave (
      output stall, redirect_valid, redirect_target, instr_readdata,
      input  instr_address, instr, pc, pc_plus8, active, fault, ds_err, fsm_state
   );
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS program counter and fetch sequencer with branch-delay-slot handling,
// halt-on-redirect-to-HALT_ADDR, and sticky misalignment / delay-slot-redirect flags.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
   parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
   input logic          clk,
   input logic          reset,
   mips_fetch_if.master bus
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DELAY  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic [31:0] pending;
   logic        active;
   logic        fault;
   logic        ds_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RUN;
         pc      <= RESET_VECTOR;
         pending <= 32'h0;
         active  <= 1'b1;
         fault   <= 1'b0;
         ds_err  <= 1'b0;
      end else if (!bus.stall) begin
         case (state)
            RUN: begin
               pc <= pc + 32'd4;
               if (bus.redirect_valid) begin
                  state <= DELAY;
                  // A misaligned target is replaced by a halt once the delay slot retires.
                  if (bus.redirect_target[1:0] == 2'b00) begin
                     pending <= bus.redirect_target;
                  end else begin
                     pending <= HALT_ADDR;
                     fault   <= 1'b1;
                  end
               end
            end
            DELAY: begin
               pc <= pending;
               if (bus.redirect_valid) ds_err <= 1'b1;
               if (pending == HALT_ADDR) begin
                  state  <= HALTED;
                  active <= 1'b0;
               end else begin
                  state <= RUN;
               end
            end
            default: begin
               state <= HALTED;
            end
         endcase
      end
   end

   assign bus.instr_address = pc;
   assign bus.pc            = pc;
   assign bus.pc_plus8      = pc + 32'd8;
   assign bus.instr         = (state == HALTED) ? 32'h0 : bus.instr_readdata;
   assign bus.active        = active;
   assign bus.fault         = fault;
   assign bus.ds_err        = ds_err;
   assign bus.fsm_state     = state;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Bench for mips_fetch_unit: directed scenarios followed by randomized redirects/stalls,
// compared every cycle against a queue-based model of the fetch address stream.
module tb_mips_fetch_unit;
   localparam logic [31:0] RV   = 32'hBFC00000;
   localparam logic [31:0] HALT = 32'h00000000;

   logic clk;
   logic reset;
   mips_fetch_if bus ();

   mips_fetch_unit #(.RESET_VECTOR(RV), .HALT_ADDR(HALT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction RAM stand-in: content is a fixed scramble of the address.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h1234ABCD;
   endfunction
   assign bus.instr_readdata = mem(bus.instr_address);

   // Reference model: current fetch address, plus a queue of fetches already
   // committed by a branch (at most the one target after the delay slot).
   logic [31:0] m_pc;
   logic [31:0] sched_q[$];
   bit          m_halted, m_fault, m_ds_err;
   int          tests_run = 0;
   int          n_fail    = 0;

   task automatic model_reset();
      m_pc = RV;
      sched_q.delete();
      m_halted = 0;
      m_fault  = 0;
      m_ds_err = 0;
   endtask

   task automatic model_clock(input logic stl, input logic rv, input logic [31:0] tgt);
      if (stl || m_halted) return;
      if (sched_q.size() != 0) begin
         if (rv) m_ds_err = 1;
         m_pc = sched_q.pop_front();
         if (m_pc == HALT) m_halted = 1;
      end else begin
         if (rv) begin
            if (tgt % 4 != 0) begin
               m_fault = 1;
               sched_q.push_back(HALT);
            end else begin
               sched_q.push_back(tgt);
            end
         end
         m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] exp_state;
      exp_state = m_halted ? 32'd2 : (sched_q.size() != 0 ? 32'd1 : 32'd0);
      check({tag, ".pc"},       bus.pc, m_pc);
      check({tag, ".addr"},     bus.instr_address, m_pc);
      check({tag, ".pc_plus8"}, bus.pc_plus8, m_pc + 32'd8);
      check({tag, ".instr"},    bus.instr, m_halted ? 32'h0 : mem(m_pc));
      check({tag, ".active"},   {31'h0, bus.active}, {31'h0, !m_halted});
      check({tag, ".fault"},    {31'h0, bus.fault}, {31'h0, m_fault});
      check({tag, ".ds_err"},   {31'h0, bus.ds_err}, {31'h0, m_ds_err});
      check({tag, ".state"},    {30'h0, bus.fsm_state}, exp_state);
   endtask

   // Drive inputs just after an edge, advance the model on the next edge, check after it.
   task automatic step(input string tag, input logic stl, input logic rv, input logic [31:0] tgt);
      bus.stall           = stl;
      bus.redirect_valid  = rv;
      bus.redirect_target = tgt;
      @(posedge clk);
      model_clock(stl, rv, tgt);
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset asserted mid-cycle and checked before any clock edge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1;
      reset = 1'b1;
      check_all({tag, ".held"});
   endtask

   initial begin
      logic [31:0] t;
      logic        s, r;
      reset = 1'b1;
      bus.stall = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = 32'h0;
      model_reset();
      #2;
      do_reset("rst0");
      check("first_pc_plus8", bus.pc_plus8, 32'hBFC00008);

      for (int i = 0; i < 3; i++) step("seq", 0, 0, 0);
      check("seq_pc3", bus.pc, 32'hBFC0000C);

      // Taken branch at 0xBFC00010
      step("seq4", 0, 0, 0);
      step("br_ds", 0, 1, 32'hBFC00100);
      check("br_ds_pc", bus.pc, 32'hBFC00014);
      step("br_tgt", 0, 0, 0);
      check("br_tgt_pc", bus.pc, 32'hBFC00100);

      // Halt: redirect to 0 from 0xBFC00020, then inputs ignored
      do_reset("rst1");
      for (int i = 0; i < 8; i++) step("to20", 0, 0, 0);
      step("halt_ds", 0, 1, 32'h0);
      check("halt_ds_pc", bus.pc, 32'hBFC00024);
      step("halt", 0, 0, 0);
      check("halt_active", {31'h0, bus.active}, 32'h0);
      for (int i = 0; i < 10; i++) step("halted", 1'($urandom_range(0, 1)), 1'(i % 2), 32'hBFC00500);
      check("halted_pc", bus.pc, 32'h0);

      // Stall during the delay slot, redirect while stalled is ignored
      do_reset("rst2");
      step("st_br", 0, 1, 32'hBFC00200);
      for (int i = 0; i < 3; i++) step("st_hold", 1, 1, 32'hBFC00900);
      step("st_tgt", 0, 0, 0);
      check("st_tgt_pc", bus.pc, 32'hBFC00200);

      // Redirect from inside the delay slot
      step("dse_br", 0, 1, 32'hBFC00300);
      step("dse_ds", 0, 1, 32'hBFC00400);
      check("dse_pc", bus.pc, 32'hBFC00300);
      for (int i = 0; i < 3; i++) step("dse_run", 0, 0, 0);
      check("dse_sticky", {31'h0, bus.ds_err}, 32'h1);

      // Misaligned target: delay slot runs, then halt with fault
      step("mis_br", 0, 1, 32'hBFC00102);
      step("mis_ds", 0, 0, 0);
      check("mis_pc", bus.pc, 32'h0);
      check("mis_fault", {31'h0, bus.fault}, 32'h1);
      do_reset("rst3");

      // Sequential wrap through zero is not a halt
      step("wr_br", 0, 1, 32'hFFFFFFF8);
      for (int i = 0; i < 4; i++) step("wrap", 0, 0, 0);
      check("wrap_pc", bus.pc, 32'h00000004);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         if (m_halted && ($urandom_range(0, 3) == 0)) do_reset("rnd_rst");
         s = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 3) == 0);
         case ($urandom_range(0, 9))
            0:       t = 32'h0;
            1:       t = $urandom() | 32'h1;
            default: t = $urandom() & 32'hFFFFFFFC;
         endcase
         step("rnd", s, r, t);
      end
      do_reset("rst_end");

      $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
      $finish;
   end
endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Program-counter and fetch-sequencing stage of the MIPS core.
- Sits directly upstream of the instruction RAM: drives the RAM's combinational read address and consumes the returned read data.
- Applies MIPS branch-delay-slot semantics to redirects from the execute logic.
- Stops fetching when control transfers to the halt address; flags misaligned targets.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
HALT_ADDR, 32'h00000000, redirect target that ends execution after the delay slot.

Ports:
clk  input  1  core clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  1 = hold PC, state and pending target this cycle.
instr_address  output  32  fetch address to instruction RAM; equals current PC.
instr_readdata  input  32  combinational read data from instruction RAM.
instr  output  32  instruction to decode; instr_readdata in RUN/DELAY, 32'h0 (nop) in HALTED.
pc  output  32  current PC.
pc_plus8  output  32  PC+8, return address for link instructions.
redirect_valid  input  1  current instruction is a taken branch or jump.
redirect_target  input  32  target for redirect_valid.
active  output  1  1 while executing; 0 once halted or faulted.
fault  output  1  sticky; misaligned redirect target.
ds_err  output  1  sticky; redirect requested from inside a delay slot.

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_VECTOR, state=RUN, pending=0.
  - active=1, fault=0, ds_err=0.
  - Applies immediately without waiting for a clock edge; abandons any pending redirect or delay slot.
- Combinational outputs:
  - instr_address=pc.
  - pc_plus8=pc+8, modulo 2^32.
  - instr as described under Ports.
- States: RUN, DELAY, HALTED.
- Stall:
  - Any state with stall=1 → pc, state, pending, fault and ds_err all unchanged.
  - Redirect inputs are ignored while stall=1.
- RUN, stall=0:
  - redirect_valid=0 → pc←pc+4, stay in RUN.
  - redirect_valid=1, redirect_target[1:0]==0 → pending←redirect_target, pc←pc+4, go to DELAY.
  - redirect_valid=1, redirect_target[1:0]!=0 → fault←1, pc←pc+4, go to DELAY with pending←HALT_ADDR. The delay slot still executes, then the unit halts.
- DELAY, stall=0 (the current instruction is the delay slot):
  - pc←pending.
  - pending==HALT_ADDR → go to HALTED, otherwise go to RUN.
  - redirect_valid=1 in DELAY → ignored, ds_err←1. The original pending target wins.
- HALTED:
  - pc holds HALT_ADDR, active=0, instr=0.
  - All inputs ignored; only reset leaves this state.
- active timing: goes 0 in the same cycle the state becomes HALTED (registered). It is never 0 in RUN or DELAY.
- Arithmetic:
  - All PC arithmetic is 32-bit and wraps: 32'hFFFFFFFC+4 = 32'h00000000.
  - Sequential wrap to 0 is NOT a halt; only a redirect to HALT_ADDR halts.
- Simultaneous events:
  - stall has priority over redirect.
  - reset has priority over everything.
- Latency:
  - Sequential fetch is one instruction per unstalled cycle.
  - A redirect takes effect exactly two fetches after the branch: branch, delay slot, then target.

Test Plan:
- Reset then 3 unstalled cycles → instr_address 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; active=1; pc_plus8=0xBFC00008 in the first cycle.
- redirect_valid=1, target=0xBFC00100 at pc=0xBFC00010 → next pc=0xBFC00014 (delay slot, state DELAY), following pc=0xBFC00100, state RUN.
- redirect_valid=1, target=0x0 at pc=0xBFC00020 → pc 0xBFC00024 for one cycle, then pc=0, active=0, instr=0. pc stays 0 for 10 further cycles despite redirect_valid=1 pulses.
- stall=1 for 3 cycles during DELAY (pending=0xBFC00200) → pc held at the delay-slot address. On the first unstalled cycle pc←0xBFC00200. A redirect_valid asserted while stalled has no effect.
- Redirect in delay slot: target A=0xBFC00300 from RUN, then redirect_valid=1, target 0xBFC00400 in DELAY → pc goes to 0xBFC00300, ds_err=1 and stays 1.
- Misaligned target 0xBFC00102 → delay slot fetched, then pc=0, active=0, fault=1. Asserting reset=0 mid-run returns pc=0xBFC00000 and clears active/fault/ds_err to 1/0/0 immediately, before any clock edge.
